// File: rtl/regwrite_scoreboard_pkg.sv
// Shared definitions for the register-writeback scoreboard.
// Holds the controller state encoding, the default parameter widths and the
// saturating increment used by the mismatch counter.
package regwrite_scoreboard_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_CYC_W    = 16;
    localparam int DEF_ERR_W    = 8;

    // Widest counter sat_inc can handle; callers zero-extend into this width
    // and truncate the result back to their own counter width.
    localparam int SAT_MAX_W = 32;

    // Increment value, holding at the all-ones value of a 'width'-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                     input int width);
        logic [SAT_MAX_W-1:0] max_val;
        if (width >= SAT_MAX_W) begin
            max_val = '1;
        end else begin
            max_val = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        end
        if (value >= max_val) begin
            return max_val;
        end
        return value + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/regwrite_scoreboard_shadow_regfile.sv
// Shadow copy of the processor register file.
// One write port, one registered read port, a synchronous clear of every
// entry, and register 0 hardwired to zero (writes to it are dropped).
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   clear             - synchronous clear of all entries and the read data
//   wr_en/addr/data   - write port; out-of-range and register-0 writes ignored
//   rd_addr           - read address, data appears on rd_data next cycle
//   rd_data           - registered read data (0 for register 0 / out of range)
module shadow_regfile
    import regwrite_scoreboard_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = wr_en && (wr_addr != '0) && ({1'b0, wr_addr} < REG_LIMIT);
    assign rd_ok = (rd_addr != '0) && ({1'b0, rd_addr} < REG_LIMIT);

    // Storage and registered read; register 0 is never written so it stays 0.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_ok) begin
                regs[wr_addr] <= wr_data;
            end
            rd_data <= rd_ok ? regs[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/regwrite_scoreboard.sv
// Register-writeback scoreboard.
// Snoops the register-file write port during a run, then sweeps an external
// expected-value table and compares every cared-for register against the
// shadow copy. Reports mismatch count, first mismatch and pass/fail.
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   start               - pulse that begins a run (accepted in IDLE or DONE)
//   cycle_limit         - run length in cycles, sampled on start (0 means 1)
//   halt                - ends the run early
//   wb_en/addr/data     - snooped register writeback
//   exp_addr, exp_rd    - expected-table read request
//   exp_data, exp_care  - table response, valid one cycle after exp_rd
//   busy, done, pass    - status
//   error_count         - saturating mismatch count
//   first_err_*         - index and shadow value of the first mismatch
//   cycles_run          - number of RUN cycles executed
module regwrite_scoreboard
    import regwrite_scoreboard_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int CYC_W    = DEF_CYC_W,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CYC_W-1:0]  cycle_limit,
    input  logic              halt,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] exp_addr,
    output logic              exp_rd,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              exp_care,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  error_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_reg,
    output logic [DATA_W-1:0] first_err_got,
    output logic [CYC_W-1:0]  cycles_run
);

    // The sweep issues NUM_REGS reads and needs one extra cycle to compare
    // the last returned value, so the check counter runs 0..NUM_REGS.
    localparam logic [ADDR_W:0] CHK_LAST = (ADDR_W+1)'(NUM_REGS);

    state_t            state;
    logic [CYC_W-1:0]  limit;
    logic [ADDR_W:0]   chk_cnt;
    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_idx;
    logic [DATA_W-1:0] shadow_q;

    logic              start_ok;
    logic              run_last;
    logic              more_reads;
    logic              mismatch;
    logic [ERR_W-1:0]  err_next;

    assign start_ok   = start && ((state == IDLE) || (state == DONE));
    assign run_last   = ((cycles_run + CYC_W'(1)) == limit) || halt;
    assign more_reads = (chk_cnt + 1'b1) < CHK_LAST;
    assign mismatch   = (state == CHECK) && cmp_valid && exp_care && (exp_data != shadow_q);
    assign err_next   = mismatch ? ERR_W'(sat_inc(SAT_MAX_W'(error_count), ERR_W)) : error_count;

    // The shadow is read at exp_addr, so its registered output lines up with
    // exp_data one cycle later without any extra delay stage.
    shadow_regfile #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_shadow (
        .clock   (clock),
        .reset   (reset),
        .clear   (start_ok),
        .wr_en   ((state == RUN) && wb_en),
        .wr_addr (wb_addr),
        .wr_data (wb_data),
        .rd_addr (exp_addr),
        .rd_data (shadow_q)
    );

    // Run controller: all status and table-request outputs are registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            limit           <= '0;
            chk_cnt         <= '0;
            cmp_valid       <= 1'b0;
            cmp_idx         <= '0;
            exp_addr        <= '0;
            exp_rd          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            error_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_reg   <= '0;
            first_err_got   <= '0;
            cycles_run      <= '0;
        end else begin
            cmp_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= RUN;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        error_count     <= '0;
                        first_err_valid <= 1'b0;
                        first_err_reg   <= '0;
                        first_err_got   <= '0;
                        cycles_run      <= '0;
                        limit           <= (cycle_limit == '0) ? CYC_W'(1) : cycle_limit;
                    end
                end
                RUN: begin
                    cycles_run <= cycles_run + CYC_W'(1);
                    if (run_last) begin
                        state    <= CHECK;
                        chk_cnt  <= '0;
                        exp_rd   <= 1'b1;
                        exp_addr <= '0;
                    end
                end
                CHECK: begin
                    chk_cnt   <= chk_cnt + 1'b1;
                    cmp_valid <= exp_rd;
                    cmp_idx   <= exp_addr;
                    if (more_reads) begin
                        exp_rd   <= 1'b1;
                        exp_addr <= ADDR_W'(chk_cnt + 1'b1);
                    end else begin
                        exp_rd   <= 1'b0;
                        exp_addr <= '0;
                    end
                    error_count <= err_next;
                    if (mismatch && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_reg   <= cmp_idx;
                        first_err_got   <= shadow_q;
                    end
                    if (chk_cnt == CHK_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regwrite_scoreboard.sv
// Testbench for regwrite_scoreboard.
// Two instances share all stimulus: one with the default 8-bit error counter
// and one with a 2-bit counter to exercise saturation. A behavioural model
// tracks the run phase, the shadow register contents and the expected table,
// and derives every output from the list of registers compared so far.
module tb_regwrite_scoreboard;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int CYC_W    = 16;

    logic              clock;
    logic              reset;
    logic              start;
    logic [CYC_W-1:0]  cycle_limit;
    logic              halt;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] exp_data;
    logic              exp_care;

    logic [ADDR_W-1:0] exp_addr;
    logic              exp_rd;
    logic              busy;
    logic              done;
    logic              pass;
    logic [7:0]        error_count;
    logic              first_err_valid;
    logic [ADDR_W-1:0] first_err_reg;
    logic [DATA_W-1:0] first_err_got;
    logic [CYC_W-1:0]  cycles_run;

    logic [ADDR_W-1:0] exp_addr_s;
    logic              exp_rd_s;
    logic              busy_s;
    logic              done_s;
    logic              pass_s;
    logic [1:0]        error_count_s;
    logic              first_err_valid_s;
    logic [ADDR_W-1:0] first_err_reg_s;
    logic [DATA_W-1:0] first_err_got_s;
    logic [CYC_W-1:0]  cycles_run_s;

    regwrite_scoreboard #(.ERR_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .cycle_limit(cycle_limit),
        .halt(halt), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .exp_addr(exp_addr), .exp_rd(exp_rd), .exp_data(exp_data), .exp_care(exp_care),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .first_err_valid(first_err_valid), .first_err_reg(first_err_reg),
        .first_err_got(first_err_got), .cycles_run(cycles_run)
    );

    regwrite_scoreboard #(.ERR_W(2)) dut_sat (
        .clock(clock), .reset(reset), .start(start), .cycle_limit(cycle_limit),
        .halt(halt), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .exp_addr(exp_addr_s), .exp_rd(exp_rd_s), .exp_data(exp_data), .exp_care(exp_care),
        .busy(busy_s), .done(done_s), .pass(pass_s), .error_count(error_count_s),
        .first_err_valid(first_err_valid_s), .first_err_reg(first_err_reg_s),
        .first_err_got(first_err_got_s), .cycles_run(cycles_run_s)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    bit chk_en       = 1'b0;

    always @(posedge clock) cyc++;

    // Expected-value table as seen by the DUT.
    logic [DATA_W-1:0] tab_exp  [NUM_REGS];
    logic              tab_care [NUM_REGS];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Table responder: a read issued in cycle k is answered during cycle k+1.
    // Without a pending read the bus carries junk, which must never be compared.
    logic              pend_valid = 1'b0;
    logic [ADDR_W-1:0] pend_addr  = '0;
    always @(negedge clock) begin
        if (pend_valid) begin
            exp_data = tab_exp[pend_addr];
            exp_care = tab_care[pend_addr];
        end else begin
            exp_data = $urandom;
            exp_care = 1'($urandom_range(0, 1));
        end
        pend_valid = exp_rd;
        pend_addr  = exp_addr;
    end

    // Behavioural model: phase 0 idle, 1 run, 2 check, 3 done.
    int                m_phase = 0;
    int                m_runs  = 0;
    int                m_limit = 1;
    int                m_chk   = 0;
    logic [DATA_W-1:0] m_shadow [NUM_REGS];
    logic [DATA_W-1:0] m_exp    [NUM_REGS];
    logic              m_care   [NUM_REGS];

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0;
            m_runs  = 0;
            m_chk   = 0;
            for (int i = 0; i < NUM_REGS; i++) m_shadow[i] = '0;
        end else begin
            case (m_phase)
                0, 3: if (start) begin
                    m_phase = 1;
                    m_runs  = 0;
                    m_limit = (cycle_limit == 0) ? 1 : int'(cycle_limit);
                    for (int i = 0; i < NUM_REGS; i++) m_shadow[i] = '0;
                end
                1: begin
                    if (wb_en && wb_addr != 0) m_shadow[wb_addr] = wb_data;
                    m_runs++;
                    if (m_runs == m_limit || halt) begin
                        m_phase = 2;
                        m_chk   = 0;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            m_exp[i]  = tab_exp[i];
                            m_care[i] = tab_care[i];
                        end
                    end
                end
                2: begin
                    m_chk++;
                    if (m_chk == NUM_REGS + 1) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Compare process: every cycle, outputs derived from the registers whose
    // comparison has already completed (one per cycle, lagging reads by one).
    always @(negedge clock) begin : compare_proc
        int compared;
        int errs;
        int first;
        bit rd_exp;
        if (chk_en) begin
            compared = (m_phase == 2) ? ((m_chk > 0) ? m_chk - 1 : 0)
                     : (m_phase == 3) ? NUM_REGS : 0;
            errs  = 0;
            first = -1;
            for (int k = 0; k < compared; k++) begin
                if (m_care[k] && (m_exp[k] !== m_shadow[k])) begin
                    errs++;
                    if (first < 0) first = k;
                end
            end
            rd_exp = (m_phase == 2) && (m_chk < NUM_REGS);
            checkOutput("busy",            64'(busy),  64'(m_phase == 1 || m_phase == 2));
            checkOutput("done",            64'(done),  64'(m_phase == 3));
            checkOutput("pass",            64'(pass),  64'(m_phase == 3 && errs == 0));
            checkOutput("error_count",     64'(error_count), 64'((errs > 255) ? 255 : errs));
            checkOutput("first_err_valid", 64'(first_err_valid), 64'(first >= 0));
            checkOutput("first_err_reg",   64'(first_err_reg), 64'((first >= 0) ? first : 0));
            checkOutput("first_err_got",   64'(first_err_got), (first >= 0) ? 64'(m_shadow[first]) : 64'(0));
            checkOutput("cycles_run",      64'(cycles_run), 64'(m_runs));
            checkOutput("exp_rd",          64'(exp_rd), 64'(rd_exp));
            if (rd_exp) checkOutput("exp_addr", 64'(exp_addr), 64'(m_chk));
            checkOutput("sat.error_count", 64'(error_count_s), 64'((errs > 3) ? 3 : errs));
            checkOutput("sat.done",        64'(done_s), 64'(m_phase == 3));
            checkOutput("sat.first_err_reg", 64'(first_err_reg_s), 64'((first >= 0) ? first : 0));
        end
    end

    task automatic applyStimulus(input logic st, input logic [CYC_W-1:0] lim, input logic hl,
                                 input logic we, input logic [ADDR_W-1:0] wa,
                                 input logic [DATA_W-1:0] wd);
        @(negedge clock);
        start       = st;
        cycle_limit = lim;
        halt        = hl;
        wb_en       = we;
        wb_addr     = wa;
        wb_data     = wd;
    endtask

    task automatic clearTable();
        for (int i = 0; i < NUM_REGS; i++) begin
            tab_exp[i]  = '0;
            tab_care[i] = 1'b0;
        end
    endtask

    // Waits for done; lat is the number of clock edges from the start edge.
    task automatic waitDone(input string name, input int acc, input int lat);
        bit seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({name, ".done_reached"}, 64'(seen), 64'(1));
        if (seen && lat > 0) checkOutput({name, ".latency"}, 64'(cyc - acc), 64'(lat));
    endtask

    initial begin
        int acc;
        int lim;
        reset = 1'b1;
        start = 1'b0; cycle_limit = '0; halt = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        exp_data = '0; exp_care = 1'b0;
        clearTable();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_exp[i] = '0; m_care[i] = 1'b0; m_shadow[i] = '0;
        end
        @(negedge clock);
        @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state
        checkOutput("reset.busy", 64'(busy), 64'(0));
        checkOutput("reset.done", 64'(done), 64'(0));
        checkOutput("reset.error_count", 64'(error_count), 64'(0));
        checkOutput("reset.cycles_run", 64'(cycles_run), 64'(0));

        // Basic pass
        clearTable();
        tab_exp[1] = 32'h5;        tab_care[1] = 1'b1;
        tab_exp[2] = 32'hFFFFFFFF; tab_care[2] = 1'b1;
        applyStimulus(1, 10, 0, 0, 0, 0);
        acc = cyc + 1;
        applyStimulus(0, 0, 0, 1, 1, 32'h5);
        applyStimulus(0, 0, 0, 1, 2, 32'hFFFFFFFF);
        waitDone("basic", acc, 43);
        checkOutput("basic.pass", 64'(pass), 64'(1));
        checkOutput("basic.error_count", 64'(error_count), 64'(0));
        checkOutput("basic.cycles_run", 64'(cycles_run), 64'(10));

        // Single mismatch (restart from DONE)
        clearTable();
        tab_exp[3] = 32'h13; tab_care[3] = 1'b1;
        applyStimulus(1, 5, 0, 0, 0, 0);
        acc = cyc + 1;
        applyStimulus(0, 0, 0, 1, 3, 32'h12);
        waitDone("mismatch", acc, 38);
        checkOutput("mismatch.error_count", 64'(error_count), 64'(1));
        checkOutput("mismatch.first_err_reg", 64'(first_err_reg), 64'(3));
        checkOutput("mismatch.first_err_got", 64'(first_err_got), 64'h12);
        checkOutput("mismatch.pass", 64'(pass), 64'(0));

        // Early halt with last-cycle write; r3 must read back cleared
        clearTable();
        tab_exp[4] = 32'hABCD; tab_care[4] = 1'b1;
        tab_exp[3] = 32'h0;    tab_care[3] = 1'b1;
        applyStimulus(1, 100, 0, 0, 0, 0);
        acc = cyc + 1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("restart.error_count", 64'(error_count), 64'(0));
        checkOutput("restart.first_err_valid", 64'(first_err_valid), 64'(0));
        for (int i = 1; i < 7; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 4, 32'hABCD);
        applyStimulus(1, 50, 0, 0, 0, 0);
        waitDone("halt", acc, 41);
        checkOutput("halt.cycles_run", 64'(cycles_run), 64'(8));
        checkOutput("halt.pass", 64'(pass), 64'(1));

        // Register-0 write and don't-care entry
        clearTable();
        tab_exp[0] = 32'h0;  tab_care[0] = 1'b1;
        tab_exp[5] = 32'h99; tab_care[5] = 1'b0;
        applyStimulus(1, 3, 0, 0, 0, 0);
        acc = cyc + 1;
        applyStimulus(0, 0, 0, 1, 0, 32'h7);
        waitDone("reg0", acc, 36);
        checkOutput("reg0.pass", 64'(pass), 64'(1));

        // Saturation: five mismatches, limit 0 gives one RUN cycle
        clearTable();
        tab_exp[6]  = 32'h1; tab_care[6]  = 1'b1;
        tab_exp[7]  = 32'h0; tab_care[7]  = 1'b1;
        tab_exp[9]  = 32'h2; tab_care[9]  = 1'b1;
        tab_exp[12] = 32'h3; tab_care[12] = 1'b1;
        tab_exp[20] = 32'h4; tab_care[20] = 1'b1;
        tab_exp[31] = 32'h5; tab_care[31] = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0);
        acc = cyc + 1;
        waitDone("sat", acc, 34);
        checkOutput("sat.count8", 64'(error_count), 64'(5));
        checkOutput("sat.count2", 64'(error_count_s), 64'(3));
        checkOutput("sat.first_reg", 64'(first_err_reg_s), 64'(6));
        checkOutput("sat.cycles_run", 64'(cycles_run), 64'(1));
        checkOutput("sat.pass", 64'(pass_s), 64'(0));

        // Reset in RUN
        applyStimulus(1, 20, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 2, 32'h55);
        applyStimulus(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rst_run.busy", 64'(busy), 64'(0));
        checkOutput("rst_run.cycles_run", 64'(cycles_run), 64'(0));
        checkOutput("rst_run.error_count", 64'(error_count), 64'(0));
        checkOutput("rst_run.exp_rd", 64'(exp_rd), 64'(0));
        checkOutput("rst_run.first_err_got", 64'(first_err_got), 64'(0));

        // Randomised runs against the model
        for (int run = 0; run < 25; run++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tab_exp[i]  = 32'($urandom_range(0, 3));
                tab_care[i] = 1'($urandom_range(0, 1));
            end
            lim = $urandom_range(0, 40);
            applyStimulus(1, 16'(lim), 0, 0, 0, 0);
            for (int n = 0; n < 300; n++) begin
                @(negedge clock);
                start   = ($urandom_range(0, 19) == 0);
                halt    = ($urandom_range(0, 29) == 0);
                wb_en   = 1'($urandom_range(0, 1));
                wb_addr = 5'($urandom_range(0, 31));
                wb_data = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3));
                reset   = ($urandom_range(0, 299) == 0);
                if (reset) begin
                    @(negedge clock);
                    reset = 1'b0;
                    start = 1'b0;
                    break;
                end
                if (done === 1'b1) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
